// File: rtl/eth_pkt_buf_pkg.sv
// Shared constants for the store-and-forward Ethernet frame buffer.
package eth_pkt_buf_pkg;
  localparam int ETH_MAX_FRAME = 1518;
  localparam int ETH_BYTE_W    = 8;
  localparam int ADDR_W_DEF    = 11;
  localparam int LQ_W_DEF      = 2;
  localparam int LEN_W_DEF     = 16;
endpackage

// File: rtl/eth_len_fifo.sv
// First-word-fall-through FIFO of committed frame lengths; head is valid whenever !empty.
module eth_len_fifo #(
  parameter int DEPTH_W = 2,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);
  localparam int DEPTH = 1 << DEPTH_W;
  localparam logic [DEPTH_W:0] CNT_FULL = {1'b1, {DEPTH_W{1'b0}}};

  logic [DATA_W-1:0]  mem_r [0:DEPTH-1];
  logic [DEPTH_W-1:0] wp_r;
  logic [DEPTH_W-1:0] rp_r;
  logic [DEPTH_W:0]   cnt_r;
  logic               do_push_s;
  logic               do_pop_s;

  assign full      = (cnt_r == CNT_FULL);
  assign empty     = (cnt_r == {(DEPTH_W+1){1'b0}});
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign head      = mem_r[rp_r];

  // Storage, pointers and occupancy; push and pop in one cycle leave occupancy unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_r  <= {DEPTH_W{1'b0}};
      rp_r  <= {DEPTH_W{1'b0}};
      cnt_r <= {(DEPTH_W+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if (do_push_s) begin
        mem_r[wp_r] <= push_data;
        wp_r        <= wp_r + {{(DEPTH_W-1){1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rp_r <= rp_r + {{(DEPTH_W-1){1'b0}}, 1'b1};
      end
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_r <= cnt_r + {{DEPTH_W{1'b0}}, 1'b1};
        2'b01:   cnt_r <= cnt_r - {{DEPTH_W{1'b0}}, 1'b1};
        default: cnt_r <= cnt_r;
      endcase
    end
  end
endmodule

// File: rtl/eth_pkt_buf.sv
// Store-and-forward frame buffer: bytes are written speculatively and only become
// readable once the frame commits; aborted/overflowing frames roll back to wr_cmt.
module eth_pkt_buf
  import eth_pkt_buf_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LQ_W   = LQ_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ETH_BYTE_W-1:0] wr_data,
  input  logic                  wr_commit,
  input  logic                  wr_abort,
  input  logic                  rd_req,
  input  logic                  rd_pkt_done,
  output logic [ETH_BYTE_W-1:0] rd_data,
  output logic                  pkt_avail,
  output logic [LEN_W-1:0]      pkt_len,
  output logic [ADDR_W:0]       free_bytes,
  output logic [LEN_W-1:0]      drop_cnt
);
  localparam int P_W = ADDR_W + 1;
  localparam logic [P_W-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [P_W-1:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

  logic [ETH_BYTE_W-1:0] mem_r [0:(1<<ADDR_W)-1];
  logic [P_W-1:0]        wr_ptr_r, wr_cmt_r, rd_ptr_r, rd_base_r, free_bytes_r;
  logic [P_W-1:0]        wr_ptr_nxt_s, wr_cmt_nxt_s, rd_ptr_nxt_s, rd_base_nxt_s;
  logic [P_W-1:0]        wr_ptr_inc_s, frm_len_s, rd_off_s, rd_end_s;
  logic                  frm_ovf_r, frm_ovf_nxt_s, ovf_now_s, full_s;
  logic                  wr_fire_s, cmt_ok_s, drop_s, rd_fire_s, pop_s;
  logic [LEN_W-1:0]      drop_cnt_r, lq_head_s;
  logic [ETH_BYTE_W-1:0] rd_data_r;
  logic                  lq_full_s, lq_empty_s;

  assign full_s       = ((wr_ptr_r - rd_base_r) == DEPTH);
  assign wr_fire_s    = wr_en & ~full_s & ~frm_ovf_r & ~wr_abort;
  assign wr_ptr_inc_s = wr_fire_s ? (wr_ptr_r + ONE) : wr_ptr_r;
  // A byte refused this very cycle already poisons a same-cycle commit.
  assign ovf_now_s    = frm_ovf_r | (wr_en & full_s);
  assign frm_len_s    = wr_ptr_inc_s - wr_cmt_r;
  assign cmt_ok_s     = wr_commit & ~wr_abort & ~ovf_now_s & (frm_len_s != {P_W{1'b0}}) & ~lq_full_s;
  assign drop_s       = wr_abort | (wr_commit & ~cmt_ok_s);

  assign pkt_avail    = ~lq_empty_s;
  assign pkt_len      = lq_empty_s ? {LEN_W{1'b0}} : lq_head_s;
  assign rd_off_s     = rd_ptr_r - rd_base_r;
  assign rd_fire_s    = rd_req & pkt_avail & (LEN_W'(rd_off_s) < pkt_len);
  assign pop_s        = rd_pkt_done & pkt_avail;
  assign rd_end_s     = rd_base_r + pkt_len[P_W-1:0];

  assign rd_data      = rd_data_r;
  assign free_bytes   = free_bytes_r;
  assign drop_cnt     = drop_cnt_r;

  eth_len_fifo #(.DEPTH_W(LQ_W), .DATA_W(LEN_W)) u_len_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cmt_ok_s),
    .push_data (LEN_W'(frm_len_s)),
    .pop       (pop_s),
    .head      (lq_head_s),
    .full      (lq_full_s),
    .empty     (lq_empty_s)
  );

  // Next-state for write-side pointers: rollback on drop, advance committed pointer on good commit.
  always_comb begin
    wr_ptr_nxt_s  = wr_ptr_inc_s;
    wr_cmt_nxt_s  = wr_cmt_r;
    frm_ovf_nxt_s = ovf_now_s;
    if (drop_s) begin
      wr_ptr_nxt_s  = wr_cmt_r;
      frm_ovf_nxt_s = 1'b0;
    end else if (cmt_ok_s) begin
      wr_cmt_nxt_s  = wr_ptr_inc_s;
      frm_ovf_nxt_s = 1'b0;
    end else begin
      wr_cmt_nxt_s  = wr_cmt_r;
    end
  end

  // Next-state for read-side pointers: a pop skips any unread bytes of the head frame.
  always_comb begin
    rd_ptr_nxt_s  = rd_ptr_r;
    rd_base_nxt_s = rd_base_r;
    if (pop_s) begin
      rd_ptr_nxt_s  = rd_end_s;
      rd_base_nxt_s = rd_end_s;
    end else if (rd_fire_s) begin
      rd_ptr_nxt_s  = rd_ptr_r + ONE;
    end else begin
      rd_ptr_nxt_s  = rd_ptr_r;
    end
  end

  // Data RAM write port (no reset so it maps onto block RAM).
  always_ff @(posedge clk) begin
    if (wr_fire_s) begin
      mem_r[wr_ptr_r[ADDR_W-1:0]] <= wr_data;
    end
  end

  // Pointer, status and read-data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r     <= {P_W{1'b0}};
      wr_cmt_r     <= {P_W{1'b0}};
      rd_ptr_r     <= {P_W{1'b0}};
      rd_base_r    <= {P_W{1'b0}};
      frm_ovf_r    <= 1'b0;
      free_bytes_r <= DEPTH;
      drop_cnt_r   <= {LEN_W{1'b0}};
      rd_data_r    <= {ETH_BYTE_W{1'b0}};
    end else begin
      wr_ptr_r     <= wr_ptr_nxt_s;
      wr_cmt_r     <= wr_cmt_nxt_s;
      rd_ptr_r     <= rd_ptr_nxt_s;
      rd_base_r    <= rd_base_nxt_s;
      frm_ovf_r    <= frm_ovf_nxt_s;
      free_bytes_r <= DEPTH - (wr_ptr_nxt_s - rd_base_nxt_s);
      if (drop_s && (drop_cnt_r != {LEN_W{1'b1}})) begin
        drop_cnt_r <= drop_cnt_r + {{(LEN_W-1){1'b0}}, 1'b1};
      end
      if (rd_fire_s) begin
        rd_data_r <= mem_r[rd_ptr_r[ADDR_W-1:0]];
      end
    end
  end
endmodule

// File: tb/tb_eth_pkt_buf.sv
// Directed self-checking bench for eth_pkt_buf; drop_cnt expectations accumulate across steps.
module tb_eth_pkt_buf;
  logic        clk = 1'b0;
  logic        rst_n, wr_en, wr_commit, wr_abort, rd_req, rd_pkt_done;
  logic [7:0]  wr_data, rd_data;
  logic        pkt_avail;
  logic [15:0] pkt_len, drop_cnt;
  logic [11:0] free_bytes;
  int          pass_cnt = 0;
  int          chk_cnt  = 0;

  eth_pkt_buf dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .wr_commit(wr_commit), .wr_abort(wr_abort), .rd_req(rd_req),
    .rd_pkt_done(rd_pkt_done), .rd_data(rd_data), .pkt_avail(pkt_avail),
    .pkt_len(pkt_len), .free_bytes(free_bytes), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic put_bytes(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = base + 8'(i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic pulse_commit();
    wr_commit = 1'b1;
    tick();
    wr_commit = 1'b0;
  endtask

  task automatic pulse_done();
    rd_pkt_done = 1'b1;
    tick();
    rd_pkt_done = 1'b0;
  endtask

  task automatic read_chk(input string tag, input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      rd_req = 1'b1;
      tick();
      check(tag, 32'(rd_data), 32'(base + 8'(i)));
    end
    rd_req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; wr_commit = 1'b0;
    wr_abort = 1'b0; rd_req = 1'b0; rd_pkt_done = 1'b0;
    tick(); tick();
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_avail", 32'(pkt_avail), 32'd0);
    check("rst_len", 32'(pkt_len), 32'd0);
    check("rst_free", 32'(free_bytes), 32'd2048);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    rst_n = 1'b1;
    tick();

    // 64-byte frame, separate commit
    put_bytes(64, 8'h00);
    check("pre_cmt_avail", 32'(pkt_avail), 32'd0);
    pulse_commit();
    check("cmt64_avail", 32'(pkt_avail), 32'd1);
    check("cmt64_len", 32'(pkt_len), 32'd64);
    check("cmt64_free", 32'(free_bytes), 32'd1984);
    read_chk("rd64", 64, 8'h00);
    rd_req = 1'b1;
    tick();
    check("rd64_past_end_hold", 32'(rd_data), 32'd63);
    rd_req = 1'b0;
    pulse_done();
    check("done64_avail", 32'(pkt_avail), 32'd0);
    check("done64_len", 32'(pkt_len), 32'd0);
    check("done64_free", 32'(free_bytes), 32'd2048);

    // aborted frame then a good one
    put_bytes(10, 8'h30);
    check("abort_pre_free", 32'(free_bytes), 32'd2038);
    wr_abort = 1'b1;
    tick();
    wr_abort = 1'b0;
    check("abort_drop", 32'(drop_cnt), 32'd1);
    check("abort_avail", 32'(pkt_avail), 32'd0);
    check("abort_free", 32'(free_bytes), 32'd2048);
    put_bytes(20, 8'hA0);
    pulse_commit();
    check("f20_len", 32'(pkt_len), 32'd20);
    read_chk("rd20", 20, 8'hA0);
    pulse_done();

    // oversize frame
    put_bytes(2048, 8'h00);
    check("ovf_full_free", 32'(free_bytes), 32'd0);
    put_bytes(52, 8'h55);
    pulse_commit();
    check("ovf_drop", 32'(drop_cnt), 32'd2);
    check("ovf_avail", 32'(pkt_avail), 32'd0);
    check("ovf_free", 32'(free_bytes), 32'd2048);

    // five frames, length queue holds four
    for (int f = 0; f < 5; f++) begin
      put_bytes(100, 8'(f * 32));
      pulse_commit();
    end
    check("lq_drop", 32'(drop_cnt), 32'd3);
    check("lq_free", 32'(free_bytes), 32'd1648);
    for (int f = 0; f < 4; f++) begin
      check("lq_avail", 32'(pkt_avail), 32'd1);
      check("lq_len", 32'(pkt_len), 32'd100);
      read_chk("lq_first", 1, 8'(f * 32));
      pulse_done();
    end
    check("lq_empty_avail", 32'(pkt_avail), 32'd0);
    check("lq_empty_free", 32'(free_bytes), 32'd2048);

    // last byte coincident with commit; commit+abort; empty commit
    put_bytes(7, 8'h50);
    wr_en = 1'b1; wr_data = 8'h57; wr_commit = 1'b1;
    tick();
    wr_en = 1'b0; wr_commit = 1'b0;
    check("last_cmt_len", 32'(pkt_len), 32'd8);
    check("last_cmt_free", 32'(free_bytes), 32'd2040);
    put_bytes(5, 8'h70);
    wr_commit = 1'b1; wr_abort = 1'b1;
    tick();
    wr_commit = 1'b0; wr_abort = 1'b0;
    check("ca_drop", 32'(drop_cnt), 32'd4);
    check("ca_len", 32'(pkt_len), 32'd8);
    check("ca_free", 32'(free_bytes), 32'd2040);
    pulse_commit();
    check("empty_cmt_drop", 32'(drop_cnt), 32'd5);
    read_chk("rd8", 8, 8'h50);
    pulse_done();
    check("rd8_free", 32'(free_bytes), 32'd2048);

    // partial read then skip to next frame; async reset mid-read
    put_bytes(50, 8'h10);
    pulse_commit();
    put_bytes(50, 8'hC0);
    pulse_commit();
    read_chk("part3", 3, 8'h10);
    pulse_done();
    check("skip_len", 32'(pkt_len), 32'd50);
    read_chk("skip_next", 2, 8'hC0);
    rd_req = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_rd_data", 32'(rd_data), 32'd0);
    check("arst_avail", 32'(pkt_avail), 32'd0);
    check("arst_len", 32'(pkt_len), 32'd0);
    check("arst_free", 32'(free_bytes), 32'd2048);
    check("arst_drop", 32'(drop_cnt), 32'd0);
    rd_req = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
